// File: rtl/timer_pkg.sv
// Shared constants for the countdown display: segment patterns, converter states
// and the double-dabble step used by the sequential binary-to-BCD converter.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        LATCH = 2'd2
    } conv_state_t;

    // Active-low segments in g..a order
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] s;
        case (digit)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // One double-dabble step on {bcd[19:0], bin[15:0]}: adjust nibbles, then shift
    function automatic logic [35:0] dabble_step(input logic [35:0] sr);
        logic [35:0] t;
        t = sr;
        for (int i = 0; i < 5; i++) begin
            if (t[16+4*i +: 4] >= 4'd5)
                t[16+4*i +: 4] = t[16+4*i +: 4] + 4'd3;
        end
        return {t[34:0], 1'b0};
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 16-bit binary to 5-digit BCD converter, one shift per clock.
// done is high for the single LATCH cycle while bcd holds the final result.
module bin2bcd_seq
    import timer_pkg::*;
(
    input  logic        clock_100Mhz,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        busy,
    output logic        done,
    output logic [19:0] bcd
);

    conv_state_t state, state_next;
    logic [35:0] shift_reg;
    logic [3:0]  bitcnt;

    always_ff @(posedge clock_100Mhz) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CONV;
            CONV:    if (bitcnt == 4'd15) state_next = LATCH;
            LATCH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CONV) || (state == LATCH);
        done = (state == LATCH);
    end

    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            shift_reg <= '0;
            bitcnt    <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    shift_reg <= {20'd0, bin};
                    bitcnt    <= '0;
                end
                CONV: begin
                    shift_reg <= dabble_step(shift_reg);
                    bitcnt    <= bitcnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign bcd = shift_reg[35:16];

endmodule

// File: rtl/timer_display.sv
// Four-digit multiplexed seven-segment display for a seconds countdown, with
// saturation at 9999, leading-zero blanking and a blinking "0" when expired.
module timer_display
    import timer_pkg::*;
#(
    parameter int REFRESH_BITS = 18,
    parameter int BLINK_BITS   = 25
) (
    input  logic        clock_100Mhz,
    input  logic        reset,
    input  logic [15:0] count,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        busy
);

    localparam logic [REFRESH_BITS+1:0] REFRESH_ONE = 1;
    localparam logic [BLINK_BITS:0]     BLINK_ONE   = 1;

    logic [15:0]       last_val;
    logic              force_conv;
    logic              start;
    logic              conv_done;
    logic [19:0]       conv_bcd;
    logic [3:0][3:0]   digits;

    logic [REFRESH_BITS+1:0] refresh_cnt, refresh_next;
    logic [BLINK_BITS:0]     blink_cnt, blink_next;
    logic [1:0]              sel;
    logic [3:0]              lead_zero;
    logic                    expired;
    logic [3:0]              an_next;
    logic [6:0]              seg_next;

    // Changes arriving while the converter is busy are picked up once it idles
    assign start = !busy && (force_conv || (count != last_val));

    bin2bcd_seq u_conv (
        .clock_100Mhz (clock_100Mhz),
        .reset        (reset),
        .start        (start),
        .bin          (count),
        .busy         (busy),
        .done         (conv_done),
        .bcd          (conv_bcd)
    );

    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            last_val   <= '0;
            force_conv <= 1'b1;
            digits     <= '0;
        end else begin
            if (start) begin
                last_val   <= count;
                force_conv <= 1'b0;
            end
            if (conv_done)
                digits <= (conv_bcd[19:16] != 4'd0) ? {4{4'd9}} : conv_bcd[15:0];
        end
    end

    // an and seg are computed from the next counter values so both land together
    always_comb begin
        refresh_next = refresh_cnt + REFRESH_ONE;
        blink_next   = blink_cnt + BLINK_ONE;
        sel          = refresh_next[REFRESH_BITS+1 -: 2];
        expired      = (digits == '0);

        lead_zero    = '0;
        lead_zero[3] = (digits[3] == 4'd0);
        lead_zero[2] = lead_zero[3] && (digits[2] == 4'd0);
        lead_zero[1] = lead_zero[2] && (digits[1] == 4'd0);

        an_next  = (expired && blink_next[BLINK_BITS]) ? 4'hF : ~(4'b0001 << sel);
        seg_next = lead_zero[sel] ? SEG_BLANK : seg_decode(digits[sel]);
    end

    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            refresh_cnt <= '0;
            blink_cnt   <= '0;
            an          <= 4'b1110;
            seg         <= SEG_0;
        end else begin
            refresh_cnt <= refresh_next;
            blink_cnt   <= blink_next;
            an          <= an_next;
            seg         <= seg_next;
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_timer_display.sv
// Directed bench for timer_display with short refresh/blink periods; digits are
// reconstructed from the scanned an/seg outputs and compared to hand values.
module tb_timer_display;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] count;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int dp_bad = 0;

    timer_display #(.REFRESH_BITS(2), .BLINK_BITS(4)) dut (
        .clock_100Mhz (clk),
        .reset        (reset),
        .count        (count),
        .an           (an),
        .seg          (seg),
        .dp           (dp),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Capture the segment pattern shown at each anode over n clocks
    task automatic read_disp(input int n, output logic [3:0][6:0] d);
        d = {4{7'h55}};
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (dp !== 1'b1) dp_bad++;
            case (an)
                4'b1110: d[0] = seg;
                4'b1101: d[1] = seg;
                4'b1011: d[2] = seg;
                4'b0111: d[3] = seg;
                default: ;
            endcase
        end
    endtask

    task automatic check_disp(input string tag, input int n, input logic [3:0][6:0] exp);
        logic [3:0][6:0] d;
        read_disp(n, d);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_d%0d", tag, i), {25'd0, d[i]}, {25'd0, exp[i]});
    endtask

    task automatic wait_conv(input string tag);
        int n;
        n = 0;
        while (!busy && n < 10) begin @(negedge clk); n++; end
        chk({tag, "_start"}, {31'd0, busy}, 32'd1);
        n = 0;
        while (busy && n < 60) begin @(negedge clk); n++; end
        chk({tag, "_done"}, {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [6:0] seg_of(input int dg);
        case (dg)
            0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30;
            4: return 7'h19; 5: return 7'h12; 6: return 7'h02; 7: return 7'h78;
            8: return 7'h00; default: return 7'h10;
        endcase
    endfunction

    function automatic logic [3:0][6:0] model(input int v);
        logic [3:0][6:0] r;
        int dg [4];
        int w;
        w = (v > 9999) ? 9999 : v;
        dg[0] = w % 10; dg[1] = (w / 10) % 10; dg[2] = (w / 100) % 10; dg[3] = w / 1000;
        for (int i = 0; i < 4; i++) r[i] = seg_of(dg[i]);
        if (w < 1000) r[3] = 7'h7F;
        if (w < 100)  r[2] = 7'h7F;
        if (w < 10)   r[1] = 7'h7F;
        return r;
    endfunction

    initial begin
        int busy_cnt, n, prev, v, ia, lena, lenb;
        logic off [80];

        // Reset values
        reset = 1'b1;
        count = 16'd20;
        repeat (3) @(negedge clk);
        chk("rst_an", {28'd0, an}, 32'he);
        chk("rst_seg", {25'd0, seg}, 32'h40);
        chk("rst_dp", {31'd0, dp}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;

        // First conversion of 20 and scan order
        busy_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (k <= 15)
                chk($sformatf("scan_an_%0d", k), {28'd0, an}, {28'd0, ~(4'b0001 << ((k >> 2) & 3))});
        end
        chk("busy_len_20", busy_cnt, 17);
        check_disp("v20", 48, {7'h7F, 7'h7F, 7'h24, 7'h40});

        // 20 -> 19, then 18 mid-conversion
        count = 16'd19;
        repeat (5) @(negedge clk);
        count = 16'd18;
        n = 0;
        while (busy && n < 40) begin @(negedge clk); n++; end
        chk("conv19_end", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("no_gap", {31'd0, busy}, 32'd1);
        check_disp("v19", 16, {7'h7F, 7'h7F, 7'h79, 7'h10});
        n = 0;
        while (busy && n < 40) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        check_disp("v18", 48, {7'h7F, 7'h7F, 7'h79, 7'h00});

        // Expired: blinking 0
        count = 16'd0;
        wait_conv("c0");
        check_disp("v0", 48, {7'h7F, 7'h7F, 7'h7F, 7'h40});
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            off[i] = (an == 4'hF);
        end
        ia = 1;
        while (ia < 40 && off[ia] == off[ia-1]) ia++;
        lena = 1;
        while (ia + lena < 80 && off[ia+lena] == off[ia]) lena++;
        lenb = 1;
        while (ia + lena + lenb < 80 && off[ia+lena+lenb] == off[ia+lena]) lenb++;
        chk("blink_run_a", lena, 16);
        chk("blink_run_b", lenb, 16);

        // Saturation and blanking
        count = 16'd12345;
        wait_conv("c12345");
        check_disp("v12345", 48, {7'h10, 7'h10, 7'h10, 7'h10});
        count = 16'd100;
        wait_conv("c100");
        check_disp("v100", 48, {7'h7F, 7'h79, 7'h40, 7'h40});

        // Reset mid-conversion
        count = 16'd4321;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_an", {28'd0, an}, 32'he);
        chk("mid_rst_seg", {25'd0, seg}, 32'h40);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        chk("busy_len_4321", busy_cnt, 17);
        check_disp("v4321", 48, {7'h19, 7'h30, 7'h24, 7'h79});

        // Random sweep against the reference model
        prev = 4321;
        for (int t = 0; t < 20; t++) begin
            v = $urandom_range(9999);
            while (v == prev) v = $urandom_range(9999);
            prev = v;
            count = v[15:0];
            wait_conv($sformatf("sw%0d", t));
            check_disp($sformatf("sweep_%0d", v), 48, model(v));
        end

        chk("dp_high", dp_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
